imem_loader: RTL and testbench

//  Boot loader and writer for the 32-bit word-indexed instruction memory. It takes a byte stream on
//  a valid/ready interface (from the UART/debug link) and assembles little-endian 32-bit words.

---
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader that writes 32-bit words into instruction RAM
// Holds the CPU in reset until a header/data/checksum stream has been loaded cleanly.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_rst_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  // Word counters need one extra bit so a full-depth count (2**ADDR_W) is representable.
  localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] hdr_count;
  logic [1:0]       bcnt;
  logic [7:0]       xor_acc;
  logic [31:0]      tcnt;
  logic             xfer;
  logic             tmo;
  logic             next_rx;
  logic             next_busy;

  assign xfer      = rx_valid & rx_ready;
  assign hdr_count = CNT_W'(rx_data) + CNT_W'(1);
  assign tmo       = (TIMEOUT != 0) && (tcnt == TMO_LAST);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state = S_HDR;
      end
      S_HDR: begin
        if (xfer)     next_state = (hdr_count > DEPTH) ? S_ERR : S_DATA;
        else if (tmo) next_state = S_ERR;
      end
      S_DATA: begin
        if (xfer) begin
          if (bcnt == 2'd3) next_state = S_WRITE;
        end else if (tmo) begin
          next_state = S_ERR;
        end
      end
      S_WRITE: begin
        next_state = (idx + CNT_W'(1) == count) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer)     next_state = (rx_data == xor_acc) ? S_DONE : S_ERR;
        else if (tmo) next_state = S_ERR;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign next_rx   = (next_state == S_HDR) || (next_state == S_DATA) || (next_state == S_CHK);
  assign next_busy = next_rx || (next_state == S_WRITE);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      we        <= 1'b0;
      waddr     <= '0;
      wd        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst_n <= 1'b0;
      count     <= '0;
      idx       <= '0;
      bcnt      <= '0;
      xor_acc   <= '0;
      tcnt      <= '0;
    end else begin
      state     <= next_state;
      rx_ready  <= next_rx;
      busy      <= next_busy;
      we        <= (next_state == S_WRITE);
      done      <= (next_state == S_DONE);
      error     <= (next_state == S_ERR);
      cpu_rst_n <= (next_state == S_IDLE) || (next_state == S_DONE);

      // Idle-cycle watchdog: restarts on every byte, frozen while the write slot is taken.
      case (state)
        S_HDR, S_DATA, S_CHK: tcnt <= xfer ? 32'd0 : tcnt + 32'd1;
        S_WRITE:              tcnt <= tcnt;
        default:              tcnt <= 32'd0;
      endcase

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            idx     <= '0;
            bcnt    <= '0;
            xor_acc <= '0;
          end
        end
        S_HDR: begin
          if (xfer) begin
            count   <= hdr_count;
            idx     <= '0;
            bcnt    <= '0;
            xor_acc <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            wd[{bcnt, 3'b000} +: 8] <= rx_data;
            xor_acc                 <= xor_acc ^ rx_data;
            bcnt                    <= bcnt + 2'd1;
            if (bcnt == 2'd3) waddr <= idx[ADDR_W-1:0];
          end
        end
        S_WRITE: begin
          idx <= idx + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
// Table-driven random loads against a stream model plus directed corner-case sequences.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  imem_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wd(wd), .busy(busy), .done(done),
    .error(error), .cpu_rst_n(cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    bit corrupt;
    int gmax;
    bit exp_done;
    bit exp_err;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] wq[$];
  logic [31:0] exp_words[$];
  logic [7:0]  strm[$];

  always @(negedge clk) if (rst_n && we) wq.push_back({waddr, wd});

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      got = rx_ready;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    if (!got) chk("handshake", 0, 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_strm(input int gmax);
    foreach (strm[i]) send_byte(strm[i], $urandom_range(gmax, 0));
  endtask

  // Reference stream: header, little-endian words, xor of data bytes.
  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] x;
    logic [31:0] w;
    strm.delete();
    exp_words.delete();
    x = 8'h00;
    strm.push_back(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      exp_words.push_back(w);
      for (int k = 0; k < 4; k++) begin
        strm.push_back(8'((w >> (8 * k)) & 32'hFF));
        x = x ^ 8'((w >> (8 * k)) & 32'hFF);
      end
    end
    strm.push_back(corrupt ? (x ^ 8'h01) : x);
  endtask

  task automatic check_image(input string nm);
    int bad;
    bad = 0;
    chk({nm, "_we_count"}, wq.size(), exp_words.size());
    foreach (exp_words[i])
      if (i >= wq.size() || wq[i] !== {8'(i), exp_words[i]}) bad++;
    chk({nm, "_image"}, bad, 0);
  endtask

  task automatic check_end(input string nm, input bit d, input bit e);
    chk({nm, "_done"}, done, d);
    chk({nm, "_error"}, error, e);
    chk({nm, "_cpu_rst_n"}, cpu_rst_n, d);
    chk({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int lat;
    int nw;
    tbl[0] = '{1, 1'b0, 0, 1'b1, 1'b0};
    tbl[1] = '{2, 1'b0, 3, 1'b1, 1'b0};
    tbl[2] = '{7, 1'b1, 2, 1'b0, 1'b1};
    tbl[3] = '{16, 1'b0, 3, 1'b1, 1'b0};
    tbl[4] = '{3, 1'b0, 1, 1'b1, 1'b0};
    tbl[5] = '{5, 1'b1, 0, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rx_ready, we, waddr, wd, busy, done, error, cpu_rst_n}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cpu_rst_n", cpu_rst_n, 1);
    chk("post_reset_busy", busy, 0);

    // Known-good two-word load
    strm = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    exp_words = '{32'h12345678, 32'hDEADBEEF};
    wq.delete();
    pulse_start();
    chk("hdr_busy", busy, 1);
    chk("hdr_cpu_held", cpu_rst_n, 0);
    send_strm(0);
    check_image("good");
    check_end("good", 1, 0);

    // Bad checksum, same data
    strm[9] = 8'h2B;
    wq.delete();
    pulse_start();
    chk("restart_clears_done", done, 0);
    send_strm(0);
    repeat (3) @(negedge clk);
    check_image("badchk");
    check_end("badchk", 0, 1);

    // Fifth byte presented during the write slot must wait
    wq.delete();
    exp_words = '{32'h12345678, 32'hDEADBEEF};
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    rx_data = 8'hEF; rx_valid = 1'b1;
    chk("bp_ready_in_write", rx_ready, 0);
    chk("bp_we", {we, waddr, wd}, {1'b1, 8'h00, 32'h12345678});
    @(negedge clk);
    chk("bp_ready_after_write", {rx_ready, we}, {1'b1, 1'b0});
    @(negedge clk);
    rx_valid = 1'b0;
    send_byte(8'hBE, 1); send_byte(8'hAD, 0); send_byte(8'hDE, 2); send_byte(8'h2A, 0);
    check_image("bp");
    check_end("bp", 1, 0);

    // Random loads from the table
    for (int t = 0; t < 6; t++) begin
      build_random(tbl[t].n, tbl[t].corrupt);
      wq.delete();
      pulse_start();
      send_strm(tbl[t].gmax);
      check_image($sformatf("tbl%0d", t));
      check_end($sformatf("tbl%0d", t), tbl[t].exp_done, tbl[t].exp_err);
    end

    // Stalled stream trips the watchdog 16 cycles after the last byte
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h78, 0);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (error) lat = i;
    end
    chk("timeout_latency", lat, 16);
    check_end("timeout", 0, 1);

    // Full depth with an ignored START in the middle
    build_random(256, 1'b0);
    wq.delete();
    pulse_start();
    for (int i = 0; i < strm.size(); i++) begin
      if (i == 400) begin
        pulse_start();
        chk("mid_start_busy", busy, 1);
      end
      send_byte(strm[i], $urandom_range(1, 0));
    end
    check_image("full");
    nw = wq.size();
    chk("full_last_waddr", (nw > 0) ? wq[nw-1][39:32] : 8'h00, 8'hFF);
    check_end("full", 1, 0);

    // Asynchronous reset in the middle of a word
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rx_data = 8'h33; rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {rx_ready, we, waddr, wd, busy, done, error, cpu_rst_n}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_cpu_still_held", cpu_rst_n, 0);
    @(negedge clk);
    chk("release_idle", {cpu_rst_n, busy, rx_ready}, 3'b100);
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    chk("no_we_after_reset", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
